platform_led_driver: RTL and testbench
======================================

# platform_led_driver

Downstream stage of the 8-bit LED PIO, placed between the PIO output port and the board LED pins. It takes the PIO's 8-bit LED pattern and drives the physical pins with global PWM brightness, an optional blink, and optional polarity inversion. It has its own Avalon-MM slave so Nios II software can configure it without changing the PIO.

## Interface
Parameters:
- `BLINK_W`, default 16: width of the blink divider register and the blink frame counter.
- `BLINK_RST`, default 16'd100: reset value of BLINK_DIV, in PWM frames.

Ports:
- `clk` in 1: single system clock.
- `reset_n` in 1: reset, asynchronous and active-low.
- `address` in 2: slave register index.
- `chipselect` in 1: slave select.
- `write_n` in 1: active-low write strobe.
- `writedata` in 32: write data.
- `readdata` out 32: read data, combinational, zero wait states.
- `led_in` in 8: LED pattern from the PIO `out_port`.
- `led_out` out 8: drive to the board LED pins, registered.

## Operation
- Write condition: `chipselect && !write_n`. Reads have no side effects.
- Register map (unused bits read 0, writes to them are ignored):
  - Address 0, CTRL:
    - bit0 `enable`, reset 1.
    - bit1 `blink_en`, reset 0.
    - bit2 `invert`, reset 0.
  - Address 1, DUTY: [7:0], reset 8'hFF.
  - Address 2, BLINK_DIV: [BLINK_W-1:0], reset `BLINK_RST`.
  - Address 3, STATUS (read-only; writes ignored):
    - [7:0] current `led_out`.
    - bit8 `blink_phase`.
    - bit9 `enable`.
- PWM counter:
  - 8-bit `pwm_cnt` counts 0..254, then wraps to 0. Frame length is 255 clocks.
  - `frame_end` is asserted when `pwm_cnt == 254`.
- Duty shadowing:
  - `duty_act` loads from DUTY on `frame_end`, so a DUTY write never glitches mid-frame.
  - `pwm_on = (pwm_cnt < duty_act)`.
  - Duty 0 means always off. Duty 255 means always on.
- Blink:
  - `blink_cnt` increments on each `frame_end`.
  - When `blink_cnt >= eff_div-1`, `blink_cnt` clears and `blink_phase` toggles.
  - `eff_div` = BLINK_DIV, except BLINK_DIV=0 is treated as 1.
  - A write to BLINK_DIV clears `blink_cnt` and sets `blink_phase=1` in the same cycle. This overrides any toggle that cycle.
  - When `blink_en=0`, `blink_cnt` holds 0 and `blink_phase` holds 1.
- Output path:
  - `led_in` is registered into `led_q`.
  - `lit = enable ? (led_q & {8{pwm_on & blink_phase}}) : 8'h00`.
  - `led_out <= invert ? ~lit : lit`.
- Reset values:
  - `led_out = 8'h00`, `readdata` reflects the reset registers.
  - `pwm_cnt = 0`, `blink_cnt = 0`, `blink_phase = 1`, `duty_act = 8'hFF`.
- A reset asserted mid-operation returns every register and counter to its reset value immediately (asynchronous). There is no partial-frame state.

## Timing
- Latency from `led_in` to `led_out` is 2 clocks (the `led_q` register, then the output register).
- A CTRL write (`enable` or `invert`) is visible on `led_out` 2 clocks after the write edge (CTRL register, then output register).
- A DUTY write takes effect from the first frame after the next `frame_end`. Worst-case delay is 255 clocks plus 2.
- Blink half-period = `eff_div` × 255 clocks.
- `readdata` is valid in the same cycle as `address`. STATUS shows `led_out` as registered, with no extra delay.

## Structure
- Package `platform_led_driver_pkg` holds:
  - Address constants: ADDR_CTRL=0, ADDR_DUTY=1, ADDR_BLINK=2, ADDR_STATUS=3.
  - CTRL bit indices.
  - Reset constants: CTRL_RST=3'b001, DUTY_RST=8'hFF.
  - PWM_MAX=254.
- Sub-module `platform_led_pwm_gen` contains `pwm_cnt`, the `duty_act` shadow, the comparator and the `frame_end` strobe.
- The top level contains the register file, the blink logic and the output register.

## Test plan
- Reset release with `led_in=8'hA5` and no writes: `led_out=8'h00` during reset, then `8'hA5` constant after 2 clocks (duty 255, enable=1).
- Write DUTY=8'h40: from the next frame boundary onward, `led_out=8'hA5` for 64 clocks and `8'h00` for 191 clocks in each 255-clock frame. DUTY=0 gives constant `8'h00`.
- Write BLINK_DIV=2, then CTRL=3'b011: `led_out` alternates `8'hA5` for 510 clocks and `8'h00` for 510 clocks. STATUS bit8 tracks the phase. BLINK_DIV=0 gives a 255-clock half-period.
- Write CTRL=3'b101 (invert on): `led_out=8'h5A` two clocks after the write. Then write CTRL=3'b100 (enable off): `led_out=8'hFF`.
- Write DUTY=8'h80 mid-frame at `pwm_cnt=10`: the current frame stays fully on (duty 255), and the new duty applies only from the next frame.
- Assert `reset_n` low mid-blink while `blink_phase=0`: `led_out=8'h00` immediately, and after release STATUS reads `8'h00 | (1<<8) | (1<<9)`. Also read addresses 0/1/2 and check they return their reset values.

Source files
------------

// File: rtl/platform_led_driver_pkg.sv
// ---------------------------------------------------------------------------
// platform_led_driver_pkg
// Shared constants and types for the LED driver placed between the LED PIO
// and the board LED pins: register addresses, CTRL bit layout, reset values
// and the PWM frame length.
// ---------------------------------------------------------------------------
package platform_led_driver_pkg;

    // Avalon-MM slave register indices
    localparam logic [1:0] ADDR_CTRL   = 2'd0;
    localparam logic [1:0] ADDR_DUTY   = 2'd1;
    localparam logic [1:0] ADDR_BLINK  = 2'd2;
    localparam logic [1:0] ADDR_STATUS = 2'd3;

    // CTRL bit indices
    localparam int CTRL_ENABLE   = 0;
    localparam int CTRL_BLINK_EN = 1;
    localparam int CTRL_INVERT   = 2;

    // Reset values
    localparam logic [2:0] CTRL_RST = 3'b001;
    localparam logic [7:0] DUTY_RST = 8'hFF;

    // Last PWM count of a frame; a frame is PWM_MAX+1 = 255 clocks long so
    // that duty 255 is always on and duty 0 is always off.
    localparam logic [7:0] PWM_MAX = 8'd254;

    // CTRL register layout, MSB first
    typedef struct packed {
        logic invert;
        logic blink_en;
        logic enable;
    } ctrl_t;

    // Builds the STATUS read word from its fields.
    function automatic logic [31:0] pack_status(input logic [7:0] led,
                                                input logic       phase,
                                                input logic       enable);
        return {22'd0, enable, phase, led};
    endfunction

endpackage

// File: rtl/platform_led_pwm_gen.sv
// ---------------------------------------------------------------------------
// platform_led_pwm_gen
// Free-running 255-clock PWM frame generator with a frame-aligned duty shadow.
// A new duty value is only taken at the end of a frame, so software writes
// never produce a truncated or stretched pulse.
//
// Ports:
//   clk       in  1  system clock
//   reset_n   in  1  asynchronous active-low reset
//   duty      in  8  requested duty (DUTY register)
//   pwm_on    out 1  high while the current count is below the active duty
//   frame_end out 1  high on the last clock of each frame (count == 254)
// ---------------------------------------------------------------------------
module platform_led_pwm_gen
    import platform_led_driver_pkg::*;
(
    input  logic       clk,
    input  logic       reset_n,
    input  logic [7:0] duty,
    output logic       pwm_on,
    output logic       frame_end
);

    logic [7:0] pwm_cnt_r;
    logic [7:0] duty_act_r;
    logic       frame_end_s;
    logic       pwm_on_s;

    // Frame strobe and comparator.
    always_comb begin
        frame_end_s = (pwm_cnt_r == PWM_MAX);
        pwm_on_s    = (pwm_cnt_r < duty_act_r);
    end

    // Frame counter (0..254) and duty shadow loaded at the frame boundary.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            pwm_cnt_r  <= 8'd0;
            duty_act_r <= DUTY_RST;
        end else begin
            if (frame_end_s) begin
                pwm_cnt_r  <= 8'd0;
                duty_act_r <= duty;
            end else begin
                pwm_cnt_r  <= pwm_cnt_r + 8'd1;
            end
        end
    end

    assign pwm_on    = pwm_on_s;
    assign frame_end = frame_end_s;

endmodule

// File: rtl/platform_led_driver.sv
// ---------------------------------------------------------------------------
// platform_led_driver
// Drives the board LED pins from the PIO LED pattern with global PWM
// brightness, optional blink and optional polarity inversion. Configured
// through a small Avalon-MM slave (CTRL, DUTY, BLINK_DIV, STATUS).
//
// Parameters:
//   BLINK_W    width of BLINK_DIV and of the blink frame counter
//   BLINK_RST  reset value of BLINK_DIV, in PWM frames
//
// Ports:
//   clk         in  1   system clock
//   reset_n     in  1   asynchronous active-low reset
//   address     in  2   slave register index
//   chipselect  in  1   slave select
//   write_n     in  1   active-low write strobe
//   writedata   in  32  write data
//   readdata    out 32  read data, combinational, zero wait states
//   led_in      in  8   LED pattern from the PIO out_port
//   led_out     out 8   registered drive to the LED pins
// ---------------------------------------------------------------------------
module platform_led_driver
    import platform_led_driver_pkg::*;
#(
    parameter int                 BLINK_W   = 16,
    parameter logic [BLINK_W-1:0] BLINK_RST = 16'd100
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic [1:0]  address,
    input  logic        chipselect,
    input  logic        write_n,
    input  logic [31:0] writedata,
    output logic [31:0] readdata,
    input  logic [7:0]  led_in,
    output logic [7:0]  led_out
);

    ctrl_t              ctrl_r;
    logic [7:0]         duty_r;
    logic [BLINK_W-1:0] blink_div_r;
    logic [BLINK_W-1:0] blink_cnt_r;
    logic               blink_phase_r;
    logic [7:0]         led_q_r;
    logic [7:0]         led_out_r;

    logic               wr_s;
    logic               blink_wr_s;
    logic [BLINK_W-1:0] eff_div_m1_s;
    logic               pwm_on_s;
    logic               frame_end_s;
    logic [7:0]         lit_s;
    logic [7:0]         led_next_s;
    logic [31:0]        readdata_s;
    logic               unused_wdata_s;

    // Upper write-data bits have no register behind them.
    assign unused_wdata_s = ^writedata;

    platform_led_pwm_gen u_pwm_gen (
        .clk       (clk),
        .reset_n   (reset_n),
        .duty      (duty_r),
        .pwm_on    (pwm_on_s),
        .frame_end (frame_end_s)
    );

    // Write decode and blink terminal count (BLINK_DIV of 0 behaves as 1).
    always_comb begin
        wr_s       = chipselect && !write_n;
        blink_wr_s = wr_s && (address == ADDR_BLINK);
        if (blink_div_r == '0) begin
            eff_div_m1_s = '0;
        end else begin
            eff_div_m1_s = blink_div_r - BLINK_W'(1);
        end
    end

    // Register file writes; STATUS is read-only.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            ctrl_r      <= ctrl_t'(CTRL_RST);
            duty_r      <= DUTY_RST;
            blink_div_r <= BLINK_RST;
        end else if (wr_s) begin
            case (address)
                ADDR_CTRL:  ctrl_r      <= ctrl_t'(writedata[2:0]);
                ADDR_DUTY:  duty_r      <= writedata[7:0];
                ADDR_BLINK: blink_div_r <= writedata[BLINK_W-1:0];
                default:    ;
            endcase
        end
    end

    // Blink frame counter and phase. A BLINK_DIV write restarts the blink
    // cycle in the lit phase and wins over a same-cycle toggle.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            blink_cnt_r   <= '0;
            blink_phase_r <= 1'b1;
        end else if (blink_wr_s || !ctrl_r.blink_en) begin
            blink_cnt_r   <= '0;
            blink_phase_r <= 1'b1;
        end else if (frame_end_s) begin
            if (blink_cnt_r >= eff_div_m1_s) begin
                blink_cnt_r   <= '0;
                blink_phase_r <= ~blink_phase_r;
            end else begin
                blink_cnt_r   <= blink_cnt_r + BLINK_W'(1);
            end
        end
    end

    // Gate the registered pattern and apply polarity.
    always_comb begin
        if (ctrl_r.enable) begin
            lit_s = led_q_r & {8{pwm_on_s & blink_phase_r}};
        end else begin
            lit_s = 8'h00;
        end
        if (ctrl_r.invert) begin
            led_next_s = ~lit_s;
        end else begin
            led_next_s = lit_s;
        end
    end

    // Input capture and output pin register.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            led_q_r   <= 8'h00;
            led_out_r <= 8'h00;
        end else begin
            led_q_r   <= led_in;
            led_out_r <= led_next_s;
        end
    end

    // Zero-wait-state read mux; unused bits read as zero.
    always_comb begin
        readdata_s = 32'd0;
        case (address)
            ADDR_CTRL:   readdata_s[2:0]         = ctrl_r;
            ADDR_DUTY:   readdata_s[7:0]         = duty_r;
            ADDR_BLINK:  readdata_s[BLINK_W-1:0] = blink_div_r;
            ADDR_STATUS: readdata_s = pack_status(led_out_r, blink_phase_r,
                                                  ctrl_r.enable);
            default:     readdata_s = 32'd0;
        endcase
    end

    assign readdata = readdata_s;
    assign led_out  = led_out_r;

endmodule

// File: tb/tb_platform_led_driver.sv
module tb_platform_led_driver;

    logic        clk = 1'b0;
    logic        reset_n;
    logic [1:0]  address;
    logic        chipselect;
    logic        write_n;
    logic [31:0] writedata;
    logic [31:0] readdata;
    logic [7:0]  led_in;
    logic [7:0]  led_out;

    always #5 clk = ~clk;

    platform_led_driver dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .address    (address),
        .chipselect (chipselect),
        .write_n    (write_n),
        .writedata  (writedata),
        .readdata   (readdata),
        .led_in     (led_in),
        .led_out    (led_out)
    );

    int n_cmp = 0;
    int n_bad = 0;

    // Reference model: n = clocks since reset release, so the PWM position
    // is simply n % 255; blink phase is derived from k = frame ends counted
    // since the blink cycle last restarted (phase toggles every eff_div).
    logic [2:0]  m_ctrl;
    logic [7:0]  m_duty;
    logic [15:0] m_div;
    logic [7:0]  m_dact;   // duty in force for the current frame
    logic [7:0]  m_ledq;   // led_in one clock ago
    logic [7:0]  m_out;
    int          m_n;
    int          m_k;

    function automatic logic m_phase();
        int eff;
        eff = (m_div == 16'd0) ? 1 : int'(m_div);
        return ((m_k / eff) % 2) == 0;
    endfunction

    function automatic logic [31:0] m_read(input logic [1:0] a);
        case (a)
            2'd0:    return {29'd0, m_ctrl};
            2'd1:    return {24'd0, m_duty};
            2'd2:    return {16'd0, m_div};
            default: return {22'd0, m_ctrl[0], m_phase(), m_out};
        endcase
    endfunction

    task automatic model_reset();
        m_ctrl = 3'b001; m_duty = 8'hFF; m_div = 16'd100; m_dact = 8'hFF;
        m_ledq = 8'h00;  m_out = 8'h00;  m_n = 0;         m_k = 0;
    endtask

    task automatic model_step();
        logic       on;
        logic       fe;
        logic       wr;
        logic [7:0] lit;
        logic [7:0] nxt_out;
        on  = (m_n % 255) < int'(m_dact);
        fe  = (m_n % 255) == 254;
        wr  = chipselect && !write_n;
        lit = m_ctrl[0] ? (m_ledq & {8{on & m_phase()}}) : 8'h00;
        nxt_out = m_ctrl[2] ? ~lit : lit;
        if (wr && address == 2'd2) m_k = 0;
        else if (!m_ctrl[1])       m_k = 0;
        else if (fe)               m_k = m_k + 1;
        if (fe) m_dact = m_duty;
        if (wr) begin
            if (address == 2'd0) m_ctrl = writedata[2:0];
            if (address == 2'd1) m_duty = writedata[7:0];
            if (address == 2'd2) m_div  = writedata[15:0];
        end
        m_ledq = led_in;
        m_out  = nxt_out;
        m_n    = m_n + 1;
    endtask

    task automatic check8(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %h expected %h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    task automatic check32(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %h expected %h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    task automatic check_int(input string tag, input int obs, input int exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0d expected %0d (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    // One clock: advance the model with the inputs held over the edge, then
    // compare outputs 1 time unit later.
    task automatic tick();
        @(posedge clk);
        model_step();
        #1;
        check8("led_out", led_out, m_out);
        check32("readdata", readdata, m_read(address));
    endtask

    task automatic run(input int cycles);
        for (int i = 0; i < cycles; i++) tick();
    endtask

    task automatic do_write(input logic [1:0] a, input logic [31:0] d);
        address = a; writedata = d; chipselect = 1'b1; write_n = 1'b0;
        tick();
        chipselect = 1'b0; write_n = 1'b1; address = 2'd3;
    endtask

    // Counts clocks with led_out equal to val over a window.
    task automatic count_val(input int cycles, input logic [7:0] val, output int hits);
        hits = 0;
        for (int i = 0; i < cycles; i++) begin
            tick();
            if (led_out === val) hits++;
        end
    endtask

    initial begin
        int  hits;
        int  guard;
        reset_n = 1'b0; address = 2'd0; chipselect = 1'b0; write_n = 1'b1;
        writedata = 32'd0; led_in = 8'hA5;
        model_reset();

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        check8("rst_led_out", led_out, 8'h00);
        check32("rst_ctrl", readdata, 32'h1);
        address = 2'd1; #1 check32("rst_duty", readdata, 32'hFF);
        address = 2'd2; #1 check32("rst_div", readdata, 32'd100);
        address = 2'd3; #1 check32("rst_status", readdata, 32'h300);
        @(negedge clk);
        reset_n = 1'b1;

        // Pattern appears two clocks after release and stays
        tick();
        check8("first_clk", led_out, 8'h00);
        tick();
        check8("second_clk", led_out, 8'hA5);
        count_val(300, 8'hA5, hits);
        check_int("steady_a5", hits, 300);

        // Duty 64/255
        do_write(2'd1, 32'h40);
        run(300);
        count_val(255, 8'hA5, hits);
        check_int("duty40_on", hits, 64);
        count_val(255, 8'h00, hits);
        check_int("duty40_off", hits, 191);

        // Duty 0 is fully off
        do_write(2'd1, 32'h0);
        run(300);
        count_val(255, 8'h00, hits);
        check_int("duty0_off", hits, 255);
        do_write(2'd1, 32'hFF);
        run(300);

        // Blink with divider 2, then divider 0 (treated as 1)
        do_write(2'd2, 32'd2);
        do_write(2'd0, 32'h3);
        run(50);
        count_val(1020, 8'hA5, hits);
        check_int("blink2_on", hits, 510);
        do_write(2'd2, 32'd0);
        run(20);
        count_val(510, 8'hA5, hits);
        check_int("blink0_on", hits, 255);

        // Invert, then disable with invert on
        do_write(2'd0, 32'h1);
        run(5);
        do_write(2'd0, 32'h5);
        check8("invert_wr_edge", led_out, 8'hA5);
        tick();
        check8("invert_on", led_out, 8'h5A);
        do_write(2'd0, 32'h4);
        tick();
        check8("disable_inv", led_out, 8'hFF);
        do_write(2'd0, 32'h1);
        run(5);

        // Mid-frame duty write at pwm_cnt 10
        guard = 0;
        while ((m_n % 255) != 10 && guard < 300) begin
            tick();
            guard++;
        end
        check_int("align_bound", ((m_n % 255) == 10) ? 1 : 0, 1);
        do_write(2'd1, 32'h80);
        count_val(244, 8'hA5, hits);
        check_int("midframe_rest", hits, 244);
        count_val(255, 8'hA5, hits);
        check_int("midframe_next", hits, 128);

        // Randomized traffic against the model
        for (int i = 0; i < 1500; i++) begin
            led_in = 8'($urandom);
            address = 2'($urandom);
            if ($urandom_range(0, 39) == 0) begin
                case ($urandom_range(0, 3))
                    0:       do_write(2'd0, {$urandom} & 32'hFFFF_FFF7);
                    1:       do_write(2'd1, $urandom);
                    2:       do_write(2'd2, {$urandom & 32'hFFFF_0000} | 32'($urandom_range(0, 3)));
                    default: do_write(2'd3, $urandom);
                endcase
            end else begin
                chipselect = 1'($urandom);
                tick();
                chipselect = 1'b0;
            end
        end

        // Reset in the dark blink phase with invert on
        led_in = 8'hA5;
        do_write(2'd1, 32'hFF);
        do_write(2'd2, 32'd1);
        do_write(2'd0, 32'h7);
        run(260);
        address = 2'd3;
        guard = 0;
        while (readdata[8] !== 1'b0 && guard < 1000) begin
            tick();
            guard++;
        end
        check_int("phase0_bound", (readdata[8] === 1'b0) ? 1 : 0, 1);
        check8("phase0_led", led_out, 8'hFF);
        #2 reset_n = 1'b0;
        #1 check8("async_rst_led", led_out, 8'h00);
        model_reset();
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset_n = 1'b1;
        address = 2'd3; #1 check32("post_rst_status", readdata, 32'h300);
        address = 2'd0; #1 check32("post_rst_ctrl", readdata, 32'h1);
        address = 2'd1; #1 check32("post_rst_duty", readdata, 32'hFF);
        address = 2'd2; #1 check32("post_rst_div", readdata, 32'd100);
        run(20);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
